gat_feat_reader: RTL and testbench
==================================

GAT_FEAT_READER -- requirements
Module: gat_feat_reader

Interface
REQ-001 SHALL have parameter NEW_FEATURE_WIDTH, default 32, meaning width of one feature word.
REQ-002 SHALL have parameter NEW_FEATURE_DEPTH, default 43328 (2708 subgraphs x 16 features), meaning number of words to read back.
REQ-003 SHALL have parameter NEW_FEATURE_ADDR_W, default $clog2(NEW_FEATURE_DEPTH), meaning the word-address width.
REQ-004 SHALL have parameter RD_LATENCY, default 2, legal 1..4, meaning the feature BRAM port-B read latency in cycles.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, meaning output buffer entries; SHALL be at least RD_LATENCY+2 and a power of two.
REQ-006 Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- gat_ready  input  1  accelerator completion level; a 0->1 edge starts a readback.
- feat_bram_enb  output  1  port-B read enable.
- feat_bram_addrb  output  NEW_FEATURE_ADDR_W+2  byte address; bits [1:0] always 0.
- feat_bram_dout  input  NEW_FEATURE_WIDTH  read data, valid RD_LATENCY cycles after the enb cycle.
- m_tdata  output  NEW_FEATURE_WIDTH  stream data.
- m_tvalid  output  1  stream valid.
- m_tready  input  1  stream ready.
- m_tlast  output  1  marks word NEW_FEATURE_DEPTH-1.
- busy  output  1  readback in progress.
- done  output  1  one-cycle pulse at end of readback.

Function
REQ-007 FSM states SHALL be IDLE, READ, DRAIN and DONE.
REQ-008 IDLE SHALL move to READ in the cycle after a registered 0->1 edge of gat_ready; the issue index and output count SHALL be cleared on that transition.
REQ-009 gat_ready edges while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-010 In READ, a read SHALL be issued (enb=1, addrb=index*4) only when issued<NEW_FEATURE_DEPTH and fifo_count+inflight<FIFO_DEPTH; the index SHALL increment by 1 per issued read.
REQ-011 inflight SHALL count reads issued but not yet returned; returned data SHALL be captured via an RD_LATENCY-deep valid shift register aligned to enb.
REQ-012 The block SHALL never drop or duplicate a word, and a captured word SHALL always find a free FIFO entry.
REQ-013 READ SHALL move to DRAIN once the last address (NEW_FEATURE_DEPTH-1) has been issued.
REQ-014 DRAIN SHALL move to DONE when inflight==0, the FIFO is empty, and the last word has handshaked.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 m_tvalid SHALL be FIFO not-empty; m_tdata SHALL be the FIFO head; a transfer SHALL occur when m_tvalid&&m_tready.
REQ-017 m_tdata and m_tlast SHALL be held stable while m_tvalid=1 and m_tready=0.
REQ-018 m_tlast SHALL be 1 only on the head word whose output index equals NEW_FEATURE_DEPTH-1.
REQ-019 Throughput: with m_tready held 1, the block SHALL sustain one word per cycle after the initial latency.
REQ-020 Latency: the first m_tvalid SHALL rise RD_LATENCY+2 cycles after the gat_ready edge.
REQ-021 FIFO push and pop in the same cycle SHALL leave the count unchanged; pop on empty and push on full SHALL be unreachable.
REQ-022 busy SHALL be 1 in READ and DRAIN, and 0 in IDLE and DONE.
REQ-023 The index counter SHALL NOT wrap; NEW_FEATURE_DEPTH=1 SHALL produce a single word with m_tlast=1.

Reset
REQ-024 rst SHALL asynchronously force the FSM to IDLE and clear index, inflight, FIFO pointers, count, the latency shift register and the edge-detect register.
REQ-025 Under rst, outputs SHALL be enb=0, addrb=0, m_tvalid=0, m_tlast=0, busy=0 and done=0.
REQ-026 Reset mid-readback SHALL discard all buffered and in-flight data; BRAM data returning after reset release SHALL be ignored.
REQ-027 If gat_ready is already 1 at reset release, no readback SHALL start until a new 0->1 edge occurs.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/READ/DRAIN/DONE) and the feature width and depth defaults used by the accelerator top.
REQ-029 The output buffer SHALL be a separate sub-module gat_sync_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, empty, full, count).

Verification
REQ-030 DEPTH=8, RD_LATENCY=2, BRAM word i = 0xA000_0000+i, m_tready=1 -> addrb 0x00,0x04..0x1C; 8 words in order; tlast only on 0xA000_0007; done pulse once.
REQ-031 Same setup with m_tready toggling 1,0,0,1 -> no loss or duplication; tdata stable while stalled; inflight+count never exceed 8.
REQ-032 m_tready=0 for 20 cycles after start -> at most 8 reads issued, enb then held 0; after release all 8 words delivered.
REQ-033 Second gat_ready edge during READ -> ignored, exactly 8 words; a new edge after done -> a second full readback starting at addrb 0.
REQ-034 rst asserted after the 3rd word handshake -> all outputs 0 immediately; no m_tvalid until the next edge, which restarts at addrb 0.
REQ-035 DEPTH=1, RD_LATENCY=4 -> single word with tlast=1; first m_tvalid 6 cycles after the edge.

Source files
------------

// File: rtl/gat_feat_reader_pkg.sv
// Shared types and defaults for the GAT feature readback path.
package gat_feat_reader_pkg;

  localparam int GAT_FEATURE_WIDTH = 32;
  localparam int GAT_FEATURE_DEPTH = 43328;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } gat_state_t;

endpackage

// File: rtl/gat_sync_fifo.sv
// Single-clock FIFO with combinational head output and occupancy count.
module gat_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/gat_feat_reader.sv
// Streams the accelerator's feature BRAM out over AXI-Stream after gat_ready rises.
module gat_feat_reader
  import gat_feat_reader_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH  = GAT_FEATURE_WIDTH,
  parameter int NEW_FEATURE_DEPTH  = GAT_FEATURE_DEPTH,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 2,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gat_ready,
  output logic                          feat_bram_enb,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W  = NEW_FEATURE_ADDR_W + 1;
  localparam int BA_W   = NEW_FEATURE_ADDR_W + 2;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(NEW_FEATURE_DEPTH);

  gat_state_t            state;
  logic                  gr_q;
  logic                  armed;
  logic [IDX_W-1:0]      index;
  logic [IDX_W-1:0]      out_cnt;
  logic                  last_sent;
  logic [CW-1:0]         inflight;
  logic [RD_LATENCY-1:0] vld_sr;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic                  start;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // armed blocks a spurious start when gat_ready is already high at reset release.
  assign start     = (state == IDLE) && gat_ready && !gr_q && armed;
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue     = (state == READ) && (index < TOTAL_IDX) && !fifo_full
                     && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign push      = vld_sr[RD_LATENCY-1];
  assign pop       = m_tvalid && m_tready;

  assign m_tvalid  = !fifo_empty;
  assign m_tlast   = !fifo_empty && (out_cnt == LAST_IDX);

  gat_sync_fifo #(
    .WIDTH (NEW_FEATURE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (feat_bram_dout),
    .dout  (m_tdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Reads are registered, so the valid shift register starts from the enb register itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      gr_q            <= 1'b0;
      armed           <= 1'b0;
      index           <= '0;
      out_cnt         <= '0;
      last_sent       <= 1'b0;
      inflight        <= '0;
      vld_sr          <= '0;
      feat_bram_enb   <= 1'b0;
      feat_bram_addrb <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      gr_q          <= gat_ready;
      if (!gat_ready) armed <= 1'b1;
      vld_sr        <= (vld_sr << 1) | RD_LATENCY'(feat_bram_enb);
      feat_bram_enb <= issue;
      done          <= 1'b0;

      if (issue) begin
        feat_bram_addrb <= BA_W'(index) << 2;
        index           <= index + IDX_W'(1);
      end

      if (issue && !push)      inflight <= inflight + CW'(1);
      else if (!issue && push) inflight <= inflight - CW'(1);

      if (pop) begin
        out_cnt <= out_cnt + IDX_W'(1);
        if (m_tlast) last_sent <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            busy      <= 1'b1;
            index     <= '0;
            out_cnt   <= '0;
            last_sent <= 1'b0;
          end
        end
        READ: begin
          if (issue && index == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0 && fifo_empty && last_sent) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gat_feat_reader.sv
// Directed bench: an 8-word/latency-2 reader and a 1-word/latency-4 reader share stimulus.
module tb_gat_feat_reader;

  localparam int A_DEPTH = 8;
  localparam int A_LAT   = 2;
  localparam int B_DEPTH = 1;
  localparam int B_LAT   = 4;

  typedef struct {
    int       sel;
    logic [3:0] pattern;
    int       stall;
    int       second_edge;
    int       exp_words;
    int       exp_first_valid;
    int       exp_done_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic gat_ready;
  logic m_tready;
  logic cur_sel;

  logic        a_enb, a_tvalid, a_tlast, a_busy, a_done;
  logic [4:0]  a_addrb;
  logic [31:0] a_dout, a_tdata;
  logic        b_enb, b_tvalid, b_tlast, b_busy, b_done;
  logic [1:0]  b_addrb;
  logic [31:0] b_dout, b_tdata;

  logic [31:0] a_pipe [A_LAT];
  logic [31:0] b_pipe [B_LAT];

  logic        s_enb, s_tvalid, s_tlast, s_busy, s_done;
  logic [31:0] s_addr, s_tdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gat_feat_reader #(
    .NEW_FEATURE_DEPTH (A_DEPTH),
    .RD_LATENCY        (A_LAT)
  ) dut_a (
    .clk             (clk),
    .rst             (rst),
    .gat_ready       (gat_ready),
    .feat_bram_enb   (a_enb),
    .feat_bram_addrb (a_addrb),
    .feat_bram_dout  (a_dout),
    .m_tdata         (a_tdata),
    .m_tvalid        (a_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (a_tlast),
    .busy            (a_busy),
    .done            (a_done)
  );

  gat_feat_reader #(
    .NEW_FEATURE_DEPTH (B_DEPTH),
    .RD_LATENCY        (B_LAT)
  ) dut_b (
    .clk             (clk),
    .rst             (rst),
    .gat_ready       (gat_ready),
    .feat_bram_enb   (b_enb),
    .feat_bram_addrb (b_addrb),
    .feat_bram_dout  (b_dout),
    .m_tdata         (b_tdata),
    .m_tvalid        (b_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (b_tlast),
    .busy            (b_busy),
    .done            (b_done)
  );

  // BRAM models: word i holds 0xA000_0000+i, garbage when the read was not enabled.
  always @(posedge clk) begin
    a_pipe[0] <= a_enb ? 32'hA000_0000 + 32'(a_addrb >> 2) : 32'hDEAD_BEEF;
    for (int k = 1; k < A_LAT; k++) a_pipe[k] <= a_pipe[k-1];
    b_pipe[0] <= b_enb ? 32'hA000_0000 + 32'(b_addrb >> 2) : 32'hDEAD_BEEF;
    for (int k = 1; k < B_LAT; k++) b_pipe[k] <= b_pipe[k-1];
  end
  assign a_dout = a_pipe[A_LAT-1];
  assign b_dout = b_pipe[B_LAT-1];

  assign s_enb    = cur_sel ? b_enb    : a_enb;
  assign s_addr   = cur_sel ? {30'b0, b_addrb} : {27'b0, a_addrb};
  assign s_tdata  = cur_sel ? b_tdata  : a_tdata;
  assign s_tvalid = cur_sel ? b_tvalid : a_tvalid;
  assign s_tlast  = cur_sel ? b_tlast  : a_tlast;
  assign s_busy   = cur_sel ? b_busy   : a_busy;
  assign s_done   = cur_sel ? b_done   : a_done;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One full readback on the selected reader, scoring every cycle at the negedge.
  task automatic applyStimulus(input vec_t v);
    int issued = 0, accepted = 0, first_valid = -1, done_cyc = -1;
    int addr_err = 0, data_err = 0, tlast_err = 0, stable_err = 0;
    int busy_err = 0, max_occ = 0, done_cnt = 0, stall_enb = 0, post_err = 0;
    int cyc = 0;
    bit finished = 0;
    logic prev_stalled = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    cur_sel = v.sel[0];
    @(negedge clk);
    gat_ready = 1'b1;
    m_tready  = 1'b0;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      if (v.second_edge != 0 && cyc == 2) gat_ready = 1'b0;
      if (v.second_edge != 0 && cyc == 3) gat_ready = 1'b1;
      m_tready = (cyc < v.stall) ? 1'b0 : v.pattern[cyc % 4];
      if (s_tvalid && first_valid < 0) first_valid = cyc;
      if (prev_stalled && (!s_tvalid || s_tdata !== prev_data || s_tlast !== prev_last))
        stable_err++;
      if (s_enb) begin
        if (s_addr !== 32'(issued * 4)) addr_err++;
        issued++;
        if (cyc >= 12 && cyc < v.stall) stall_enb++;
      end
      if (issued - accepted > max_occ) max_occ = issued - accepted;
      if (s_busy !== !s_done) busy_err++;
      if (s_done) begin
        done_cnt++;
        done_cyc = cyc;
        finished = 1;
      end
      if (s_tvalid) begin
        if (s_tlast !== (accepted == v.exp_words - 1)) tlast_err++;
        if (m_tready) begin
          if (s_tdata !== 32'hA000_0000 + 32'(accepted)) data_err++;
          accepted++;
        end
      end
      prev_stalled = s_tvalid && !m_tready;
      prev_data    = s_tdata;
      prev_last    = s_tlast;
      cyc++;
    end
    m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_enb || s_tvalid || s_busy || s_done) post_err++;
    end
    gat_ready = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("finished_in_budget", finished, 1);
    checkOutput("first_valid_cycle", first_valid, v.exp_first_valid);
    checkOutput("words_accepted", accepted, v.exp_words);
    checkOutput("reads_issued", issued, v.exp_words);
    checkOutput("addr_errors", addr_err, 0);
    checkOutput("data_errors", data_err, 0);
    checkOutput("tlast_errors", tlast_err, 0);
    checkOutput("stall_stability_errors", stable_err, 0);
    checkOutput("busy_errors", busy_err, 0);
    checkOutput("occupancy_within_8", (max_occ <= 8), 1);
    checkOutput("enb_while_saturated", stall_enb, 0);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("done_cycle", done_cyc, v.exp_done_cyc);
    checkOutput("activity_after_done", post_err, 0);
  endtask

  vec_t vecs [6];

  initial begin
    int idle_err;
    int got;

    vecs[0] = '{0, 4'b1111, 0,  0, 8, 4, 13};
    vecs[1] = '{0, 4'b1001, 0,  0, 8, 4, 21};
    vecs[2] = '{0, 4'b1111, 20, 0, 8, 4, 29};
    vecs[3] = '{0, 4'b1111, 0,  1, 8, 4, 13};
    vecs[4] = '{1, 4'b1111, 0,  0, 1, 6, 8};
    vecs[5] = '{1, 4'b0011, 3,  0, 1, 6, 10};

    cur_sel   = 1'b0;
    rst       = 1'b1;
    gat_ready = 1'b1;
    m_tready  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs_a", {a_enb, a_addrb, a_tvalid, a_tlast, a_busy, a_done}, 0);
    checkOutput("reset_outputs_b", {b_enb, b_addrb, b_tvalid, b_tlast, b_busy, b_done}, 0);

    // gat_ready already high at release must not start anything.
    rst = 1'b0;
    idle_err = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_busy || a_enb || a_tvalid || b_busy || b_enb || b_tvalid) idle_err++;
    end
    checkOutput("no_start_on_high_level", idle_err, 0);
    gat_ready = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    m_tready = 1'b1;
    repeat (30) @(negedge clk);

    // Reset right after the third handshake, then a clean restart from address 0.
    cur_sel   = 1'b0;
    gat_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && got < 3; i++) begin
      @(negedge clk);
      if (a_tvalid) got++;
    end
    checkOutput("three_words_before_reset", got, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 checkOutput("outputs_at_reset", {a_enb, a_addrb, a_tvalid, a_tlast, a_busy, a_done}, 0);
    @(negedge clk);
    gat_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_err = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (a_tvalid || a_enb || a_busy) idle_err++;
    end
    checkOutput("quiet_after_reset", idle_err, 0);
    applyStimulus(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
